// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306-class OLED power-up sequencer.
// Holds the step opcodes, pin selects, step-entry struct, FSM states,
// SSD1306 command bytes and the 19-entry init ROM.
package oled_pkg;

  localparam int unsigned NUM_STEPS = 19;
  localparam int unsigned STEP_W    = 5;

  // SSD1306 command bytes used during init
  localparam logic [7:0] CMD_DISPLAY_OFF   = 8'hAE;
  localparam logic [7:0] CMD_CHARGE_PUMP   = 8'h8D;
  localparam logic [7:0] CMD_CP_ENABLE     = 8'h14;
  localparam logic [7:0] CMD_PRECHARGE     = 8'hD9;
  localparam logic [7:0] CMD_PRECHARGE_VAL = 8'hF1;
  localparam logic [7:0] CMD_SEG_REMAP     = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN_DEC  = 8'hC8;
  localparam logic [7:0] CMD_COM_PINS      = 8'hDA;
  localparam logic [7:0] CMD_COM_PINS_VAL  = 8'h20;
  localparam logic [7:0] CMD_DISPLAY_ON    = 8'hAF;

  typedef enum logic [2:0] {
    OpSet,
    OpWaitS,
    OpWaitL,
    OpSend,
    OpEnd
  } op_e;

  typedef enum logic [1:0] {
    PinVdd,
    PinRes,
    PinVbat
  } pin_e;

  // pin/level are used by OpSet, data by OpSend; other fields are don't-care
  typedef struct packed {
    op_e        op;
    pin_e       pin;
    logic       level;
    logic [7:0] data;
  } step_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSend,
    StGap,
    StDone
  } state_e;

  localparam step_t INIT_ROM [NUM_STEPS] = '{
    '{OpSet,   PinVdd,  1'b0, 8'h00},
    '{OpWaitS, PinVdd,  1'b0, 8'h00},
    '{OpSend,  PinVdd,  1'b0, CMD_DISPLAY_OFF},
    '{OpSet,   PinRes,  1'b0, 8'h00},
    '{OpWaitS, PinVdd,  1'b0, 8'h00},
    '{OpSet,   PinRes,  1'b1, 8'h00},
    '{OpWaitS, PinVdd,  1'b0, 8'h00},
    '{OpSend,  PinVdd,  1'b0, CMD_CHARGE_PUMP},
    '{OpSend,  PinVdd,  1'b0, CMD_CP_ENABLE},
    '{OpSend,  PinVdd,  1'b0, CMD_PRECHARGE},
    '{OpSend,  PinVdd,  1'b0, CMD_PRECHARGE_VAL},
    '{OpSet,   PinVbat, 1'b0, 8'h00},
    '{OpWaitL, PinVdd,  1'b0, 8'h00},
    '{OpSend,  PinVdd,  1'b0, CMD_SEG_REMAP},
    '{OpSend,  PinVdd,  1'b0, CMD_COM_SCAN_DEC},
    '{OpSend,  PinVdd,  1'b0, CMD_COM_PINS},
    '{OpSend,  PinVdd,  1'b0, CMD_COM_PINS_VAL},
    '{OpSend,  PinVdd,  1'b0, CMD_DISPLAY_ON},
    '{OpEnd,   PinVdd,  1'b0, 8'h00}
  };

endpackage

// File: rtl/oled_delay_timer.sv
// Inter-step delay timer for the OLED sequencer.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   delay_en      - count while high; counter clears whenever low
//   delay_sel     - 0: short wait, 1: long wait
//   delay_done    - high in the DLY-th cycle of continuous enable
// The counter saturates at its terminal count, so it never wraps mid-wait.
module oled_delay_timer #(
  parameter int unsigned DLY_SHORT_CYC = 200000,
  parameter int unsigned DLY_LONG_CYC  = 10000000,
  parameter int unsigned DLY_W         = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic delay_en,
  input  logic delay_sel,
  output logic delay_done
);

  localparam logic [DLY_W-1:0] SHORT_TC = DLY_W'(DLY_SHORT_CYC - 1);
  localparam logic [DLY_W-1:0] LONG_TC  = DLY_W'(DLY_LONG_CYC - 1);

  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] tc;

  always_comb begin
    tc    = delay_sel ? LONG_TC : SHORT_TC;
    cnt_d = cnt_q;
    if (!delay_en) begin
      cnt_d = '0;
    end else if (cnt_q < tc) begin
      cnt_d = cnt_q + DLY_W'(1);
    end
    // Cycle 1 of enable sees count 0, so cycle DLY sees the terminal count
    delay_done = delay_en && (cnt_q == tc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oled_pwr_seq.sv
// Power-up and initialisation sequencer for an SSD1306-class OLED panel.
// Walks the init ROM: drives the supply/reset pins, waits with the delay
// timer, and pushes command bytes through the SPI byte-sender.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   start         - begins the sequence when sampled high in idle
//   spi_data/load - command byte and request to the SPI sender
//   spi_done      - one-cycle pulse when the byte has been shifted out
//   oled_dc       - data/command select, always command (0)
//   oled_res_n, oled_vdd_n, oled_vbat_n - panel pins, active low
//   busy          - sequence in progress
//   init_done     - sequence complete, sticky until reset
module oled_pwr_seq
  import oled_pkg::*;
#(
  parameter int unsigned DLY_SHORT_CYC = 200000,
  parameter int unsigned DLY_LONG_CYC  = 10000000,
  parameter int unsigned DLY_W         = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] spi_data,
  output logic       spi_load,
  input  logic       spi_done,
  output logic       oled_dc,
  output logic       oled_res_n,
  output logic       oled_vdd_n,
  output logic       oled_vbat_n,
  output logic       busy,
  output logic       init_done
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [7:0]          spi_data_q, spi_data_d;
  logic                spi_load_q, spi_load_d;
  logic                res_n_q, res_n_d;
  logic                vdd_n_q, vdd_n_d;
  logic                vbat_n_q, vbat_n_d;
  logic                busy_q, busy_d;
  logic                init_done_q, init_done_d;

  step_t entry;
  logic  delay_en;
  logic  delay_sel;
  logic  delay_done;

  assign entry = INIT_ROM[step_q];

  oled_delay_timer #(
    .DLY_SHORT_CYC (DLY_SHORT_CYC),
    .DLY_LONG_CYC  (DLY_LONG_CYC),
    .DLY_W         (DLY_W)
  ) u_delay_timer (
    .clock      (clock),
    .reset      (reset),
    .delay_en   (delay_en),
    .delay_sel  (delay_sel),
    .delay_done (delay_done)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    spi_data_d  = spi_data_q;
    spi_load_d  = spi_load_q;
    res_n_d     = res_n_q;
    vdd_n_d     = vdd_n_q;
    vbat_n_d    = vbat_n_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;

    // Step index is frozen during a wait, so the ROM entry selects the length
    delay_en  = (state_q == StWait);
    delay_sel = (entry.op == OpWaitL);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          step_d  = '0;
          busy_d  = 1'b1;
        end
      end

      StFetch: begin
        case (entry.op)
          OpSet: begin
            case (entry.pin)
              PinVdd:  vdd_n_d  = entry.level;
              PinRes:  res_n_d  = entry.level;
              PinVbat: vbat_n_d = entry.level;
              default: ;
            endcase
            step_d = step_q + STEP_W'(1);
          end
          OpWaitS, OpWaitL: begin
            state_d = StWait;
          end
          OpSend: begin
            spi_data_d = entry.data;
            spi_load_d = 1'b1;
            state_d    = StSend;
          end
          default: begin
            // OpEnd, and any unused encoding, finishes the sequence
            state_d     = StDone;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
          end
        endcase
      end

      StWait: begin
        if (delay_done) begin
          step_d  = step_q + STEP_W'(1);
          state_d = StFetch;
        end
      end

      StSend: begin
        if (spi_done) begin
          spi_load_d = 1'b0;
          state_d    = StGap;
        end
      end

      StGap: begin
        // One cycle with load low so the sender sees a fresh request edge
        step_d  = step_q + STEP_W'(1);
        state_d = StFetch;
      end

      StDone: ;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      step_q      <= '0;
      spi_data_q  <= 8'h00;
      spi_load_q  <= 1'b0;
      res_n_q     <= 1'b1;
      vdd_n_q     <= 1'b1;
      vbat_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      spi_data_q  <= spi_data_d;
      spi_load_q  <= spi_load_d;
      res_n_q     <= res_n_d;
      vdd_n_q     <= vdd_n_d;
      vbat_n_q    <= vbat_n_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi_data    = spi_data_q;
  assign spi_load    = spi_load_q;
  assign oled_dc     = 1'b0;
  assign oled_res_n  = res_n_q;
  assign oled_vdd_n  = vdd_n_q;
  assign oled_vbat_n = vbat_n_q;
  assign busy        = busy_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_oled_pwr_seq.sv
// Self-checking bench for oled_pwr_seq with short delays (20 / 50 cycles).
// A procedural timeline model predicts every output each cycle; a monitor
// logs bytes and pin edges for hand-computed timing and ordering checks.
module tb_oled_pwr_seq;

  localparam int unsigned DS = 20;
  localparam int unsigned DL = 50;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       spi_done;
  logic       spi_done_model = 1'b0;
  logic       spi_spur = 1'b0;
  logic [7:0] spi_data;
  logic       spi_load;
  logic       oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n, busy, init_done;

  assign spi_done = spi_done_model | spi_spur;

  oled_pwr_seq #(
    .DLY_SHORT_CYC (DS),
    .DLY_LONG_CYC  (DL),
    .DLY_W         (24)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .spi_data    (spi_data),
    .spi_load    (spi_load),
    .spi_done    (spi_done),
    .oled_dc     (oled_dc),
    .oled_res_n  (oled_res_n),
    .oled_vdd_n  (oled_vdd_n),
    .oled_vbat_n (oled_vbat_n),
    .busy        (busy),
    .init_done   (init_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- SPI sender model ----------------
  bit stall_8d = 1'b0;
  int age = 0;
  always @(negedge clock) begin
    spi_done_model = 1'b0;
    if (spi_load === 1'b1) begin
      age++;
      if (age == ((stall_8d && spi_data == 8'h8D) ? 40 : 3)) spi_done_model = 1'b1;
    end else begin
      age = 0;
    end
  end

  // ---------------- behavioural model ----------------
  // Opcodes: 0 SET, 1 WAIT short, 2 WAIT long, 3 SEND, 4 END.
  // SET args: 0 vdd_n low, 1 res_n low, 2 res_n high, 3 vbat_n low.
  int m_op  [19] = '{0, 1, 3, 0, 1, 0, 1, 3, 3, 3, 3, 0, 2, 3, 3, 3, 3, 3, 4};
  int m_arg [19] = '{0, 0, 'hAE, 1, 0, 2, 0, 'h8D, 'h14, 'hD9, 'hF1, 3, 0,
                     'hA1, 'hC8, 'hDA, 'h20, 'hAF, 0};
  logic [7:0] exp_bytes [10] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                                 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

  logic [7:0] exp_data = 8'h00;
  logic exp_load = 0, exp_res_n = 1, exp_vdd_n = 1, exp_vbat_n = 1;
  logic exp_busy = 0, exp_init_done = 0;
  bit   done_s, aborted;

  task automatic tick();
    @(posedge clock);
    done_s = spi_done;
    if (reset) begin
      exp_data = 8'h00; exp_load = 0; exp_res_n = 1; exp_vdd_n = 1;
      exp_vbat_n = 1; exp_busy = 0; exp_init_done = 0;
      aborted = 1;
    end
  endtask

  task automatic run_seq();
    aborted = 0;
    for (int i = 0; i < 19; i++) begin
      case (m_op[i])
        0: begin
          tick(); if (aborted) return;
          case (m_arg[i])
            0: exp_vdd_n = 0;
            1: exp_res_n = 0;
            2: exp_res_n = 1;
            default: exp_vbat_n = 0;
          endcase
        end
        1, 2: begin
          tick(); if (aborted) return;
          for (int k = 0; k < ((m_op[i] == 1) ? DS : DL); k++) begin
            tick(); if (aborted) return;
          end
        end
        3: begin
          tick(); if (aborted) return;
          exp_load = 1; exp_data = 8'(m_arg[i]);
          forever begin
            tick(); if (aborted) return;
            if (done_s) break;
          end
          exp_load = 0;
          tick(); if (aborted) return;
        end
        default: begin
          tick(); if (aborted) return;
          exp_busy = 0; exp_init_done = 1;
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      tick();
      if (!reset && start && !exp_init_done) begin
        exp_busy = 1;
        run_seq();
      end
    end
  end

  always @(negedge clock) begin
    if (cyc > 0) begin
      check("spi_data",    32'(spi_data),    32'(exp_data));
      check("spi_load",    32'(spi_load),    32'(exp_load));
      check("oled_dc",     32'(oled_dc),     32'(1'b0));
      check("oled_res_n",  32'(oled_res_n),  32'(exp_res_n));
      check("oled_vdd_n",  32'(oled_vdd_n),  32'(exp_vdd_n));
      check("oled_vbat_n", 32'(oled_vbat_n), 32'(exp_vbat_n));
      check("busy",        32'(busy),        32'(exp_busy));
      check("init_done",   32'(init_done),   32'(exp_init_done));
    end
  end

  // ---------------- event monitor ----------------
  logic [7:0] bytes [$];
  int rise_c [$];
  int fall_c [$];
  int t_vdd_fall = 0, t_vbat_fall = 0, t_res_fall = 0, t_res_rise = 0;
  bit data_moved = 0, dc_seen_high = 0;
  logic [7:0] held = 8'h00;
  logic p_load = 0, p_vdd = 1, p_vbat = 1, p_res = 1;

  always @(negedge clock) begin
    if (cyc > 0) begin
      if (spi_load && !p_load) begin
        bytes.push_back(spi_data);
        rise_c.push_back(cyc);
        held = spi_data;
      end else if (spi_load && spi_data !== held) begin
        data_moved = 1;
      end
      if (!spi_load && p_load) fall_c.push_back(cyc);
      if (!oled_vdd_n && p_vdd) t_vdd_fall = cyc;
      if (!oled_vbat_n && p_vbat) t_vbat_fall = cyc;
      if (!oled_res_n && p_res) t_res_fall = cyc;
      if (oled_res_n && !p_res) t_res_rise = cyc;
      if (oled_dc !== 1'b0) dc_seen_high = 1;
      p_load = spi_load; p_vdd = oled_vdd_n; p_vbat = oled_vbat_n; p_res = oled_res_n;
    end
  end

  function automatic int bget(input int i);
    if (i < bytes.size()) return int'(bytes[i]);
    return -1;
  endfunction
  function automatic int rget(input int i);
    if (i < rise_c.size()) return rise_c[i];
    return -1000;
  endfunction
  function automatic int fget(input int i);
    if (i < fall_c.size()) return fall_c[i];
    return -1000;
  endfunction

  task automatic clear_logs();
    bytes.delete(); rise_c.delete(); fall_c.delete();
    data_moved = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (init_done === 1'b1) break;
    end
    check(name, 32'(init_done), 32'(1'b1));
  endtask

  task automatic wait_vbat(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (oled_vbat_n === 1'b0) break;
    end
    check(name, 32'(oled_vbat_n), 32'(1'b0));
  endtask

  task automatic check_bytes(input string name);
    check({name, "_count"}, 32'(bytes.size()), 32'd10);
    for (int i = 0; i < 10; i++) check({name, "_byte"}, 32'(bget(i)), 32'(exp_bytes[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held with start high
    reset = 1; start = 1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_busy",   32'(busy),        32'(1'b0));
    check("rst_load",   32'(spi_load),    32'(1'b0));
    check("rst_data",   32'(spi_data),    32'h00);
    check("rst_vdd_n",  32'(oled_vdd_n),  32'(1'b1));
    check("rst_vbat_n", 32'(oled_vbat_n), 32'(1'b1));
    check("rst_res_n",  32'(oled_res_n),  32'(1'b1));
    check("rst_init",   32'(init_done),   32'(1'b0));
    reset = 0; start = 0;
    repeat (3) @(negedge clock);
    check("idle_busy", 32'(busy), 32'(1'b0));

    // Full sequence with a stalled 8D and a spurious done in the long wait
    clear_logs();
    stall_8d = 1;
    pulse_start();
    wait_vbat("seq1_vbat_timeout");
    repeat (10) @(negedge clock);
    spi_spur = 1;
    @(negedge clock);
    spi_spur = 0;
    wait_done("seq1_done_timeout");
    stall_8d = 0;
    check_bytes("seq1");
    check("vdd_to_load",    32'(rget(0) - t_vdd_fall),  32'd22);
    check("vbat_to_load",   32'(rget(5) - t_vbat_fall), 32'd52);
    check("res_low_width",  32'(t_res_rise - t_res_fall), 32'd22);
    check("stall_8d_high",  32'(fget(1) - rget(1)), 32'd40);
    check("stall_8d_data",  32'(data_moved), 32'd0);
    check("gap_before_14",  32'(rget(2) - fget(1)), 32'd2);
    for (int i = 3; i < 10; i++) begin
      if (i != 5) check("send_gap", 32'(rget(i) - fget(i - 1)), 32'd2);
    end
    check("pin_order", 32'((t_vdd_fall < t_res_fall) && (t_res_fall < t_res_rise) &&
                           (t_res_rise < t_vbat_fall)), 32'd1);
    check("dc_low", 32'(dc_seen_high), 32'd0);
    check("seq1_busy", 32'(busy), 32'(1'b0));

    // Reset during the long wait, then replay
    do_reset();
    clear_logs();
    pulse_start();
    wait_vbat("seq2_vbat_timeout");
    repeat (20) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("midrst_vdd_n",  32'(oled_vdd_n),  32'(1'b1));
    check("midrst_vbat_n", 32'(oled_vbat_n), 32'(1'b1));
    check("midrst_res_n",  32'(oled_res_n),  32'(1'b1));
    check("midrst_busy",   32'(busy),        32'(1'b0));
    reset = 0;
    repeat (5) @(negedge clock);
    check("midrst_stays_idle", 32'(busy), 32'(1'b0));
    clear_logs();
    pulse_start();
    wait_done("seq2_done_timeout");
    check_bytes("replay");

    // Start held high through and after the sequence
    do_reset();
    clear_logs();
    @(negedge clock); start = 1;
    wait_done("seq3_done_timeout");
    repeat (100) @(negedge clock);
    check("held_start_count", 32'(bytes.size()), 32'd10);
    check("held_start_init",  32'(init_done), 32'(1'b1));
    check("held_start_busy",  32'(busy), 32'(1'b0));
    start = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
